// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, pixel/address types and fill FSM states
// for the VGA write-side blocks.
package vga_pkg;

    localparam int H_RES  = 320;
    localparam int V_RES  = 200;
    localparam int ADDR_W = 16;
    localparam int PIX_W  = 12;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/vga_xy_to_addr.sv
// Combinational (x, y) -> row-major framebuffer address.
// y*320 is built as y*256 + y*64 so no multiplier is needed.
module vga_xy_to_addr
    import vga_pkg::*;
(
    input  logic [8:0] x,
    input  logic [7:0] y,
    output fb_addr_t   addr
);

    fb_addr_t y_ext;
    fb_addr_t x_ext;

    assign y_ext = {8'b0, y};
    assign x_ext = {7'b0, x};
    assign addr  = (y_ext << 8) + (y_ext << 6) + x_ext;

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a command to the 320x200 framebuffer and
// streams one registered pixel write per cycle in raster order.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic              main_clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [8:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [8:0]        cmd_w,
    input  logic [7:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              busy,
    output logic              do_write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [PIX_W-1:0]  write_data
);

    localparam logic [8:0] H_RES_9 = 9'(H_RES);
    localparam logic [7:0] V_RES_8 = 8'(V_RES);
    localparam fb_addr_t   PITCH   = fb_addr_t'(H_RES);

    fill_state_t state_q, state_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        do_write_q, do_write_d;
    fb_addr_t    write_addr_q, write_addr_d;
    pixel_t      write_data_q, write_data_d;
    fb_addr_t    addr_q, addr_d;
    fb_addr_t    row_base_q, row_base_d;
    logic [8:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [8:0]  w_last_q, w_last_d;
    logic [7:0]  h_last_q, h_last_d;
    pixel_t      color_q, color_d;

    fb_addr_t    start_addr;
    logic        accept;
    logic        cmd_empty;
    logic [8:0]  x_room;
    logic [7:0]  y_room;
    logic [8:0]  w_eff;
    logic [7:0]  h_eff;

    vga_xy_to_addr u_xy_to_addr (
        .x    (cmd_x),
        .y    (cmd_y),
        .addr (start_addr)
    );

    // Room is only meaningful when the origin is on-screen; cmd_empty covers the rest.
    always_comb begin
        accept    = cmd_valid && ready_q;
        x_room    = H_RES_9 - cmd_x;
        y_room    = V_RES_8 - cmd_y;
        w_eff     = (cmd_w < x_room) ? cmd_w : x_room;
        h_eff     = (cmd_h < y_room) ? cmd_h : y_room;
        cmd_empty = (cmd_x >= H_RES_9) || (cmd_y >= V_RES_8) ||
                    (cmd_w == 9'd0) || (cmd_h == 8'd0);
    end

    always_comb begin
        state_d      = state_q;
        do_write_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        col_d        = col_q;
        row_d        = row_q;
        w_last_d     = w_last_q;
        h_last_d     = h_last_q;
        color_d      = color_q;

        case (state_q)
            IDLE: begin
                if (accept && !cmd_empty) begin
                    state_d    = FILL;
                    addr_d     = start_addr;
                    row_base_d = start_addr;
                    col_d      = 9'd0;
                    row_d      = 8'd0;
                    w_last_d   = w_eff - 9'd1;
                    h_last_d   = h_eff - 8'd1;
                    color_d    = cmd_color;
                end
            end
            FILL: begin
                do_write_d   = 1'b1;
                write_addr_d = addr_q;
                write_data_d = color_q;
                if (col_q == w_last_q) begin
                    col_d = 9'd0;
                    if (row_q == h_last_q) begin
                        state_d = IDLE;
                    end else begin
                        row_d      = row_q + 8'd1;
                        row_base_d = row_base_q + PITCH;
                        addr_d     = row_base_q + PITCH;
                    end
                end else begin
                    col_d  = col_q + 9'd1;
                    addr_d = addr_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready/busy follow the next state so ready rises in the cycle of the last write.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == FILL);
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            do_write_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            addr_q       <= '0;
            row_base_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            w_last_q     <= '0;
            h_last_q     <= '0;
            color_q      <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            do_write_q   <= do_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            col_q        <= col_d;
            row_q        <= row_d;
            w_last_q     <= w_last_d;
            h_last_q     <= h_last_d;
            color_q      <= color_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign do_write   = do_write_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: table of fill commands plus
// hand-written back-to-back and reset-mid-fill sequences.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic              main_clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [8:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [8:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [PIX_W-1:0]  cmd_color;
    logic              busy;
    logic              do_write;
    logic [ADDR_W-1:0] write_addr;
    logic [PIX_W-1:0]  write_data;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int color;
        int expCount;
        int expWeff;
        int expFirst;
        int expLast;
    } vec_t;

    vec_t vecs[10];

    vga_rect_fill dut (
        .main_clk   (main_clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .busy       (busy),
        .do_write   (do_write),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    always #5 main_clk = ~main_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge main_clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL %s ready timeout: got %0d, expected 1", name, cmd_ready);
        end
    endtask

    task automatic driveCmd(input int x, input int y, input int w, input int h, input int color);
        cmd_x     = x[8:0];
        cmd_y     = y[7:0];
        cmd_w     = w[8:0];
        cmd_h     = h[7:0];
        cmd_color = color[PIX_W-1:0];
        cmd_valid = 1'b1;
    endtask

    task automatic scrambleCmd();
        cmd_valid = 1'b0;
        cmd_x     = 9'($urandom);
        cmd_y     = 8'($urandom);
        cmd_w     = 9'($urandom);
        cmd_h     = 8'($urandom);
        cmd_color = PIX_W'($urandom);
    endtask

    // One command from the table: accept, then follow it cycle by cycle.
    task automatic applyStimulus(input vec_t v, input int idx);
        int    writes = 0;
        int    firstAddr = -1;
        int    lastAddr = -1;
        int    expAddr;
        string tag;
        tag = $sformatf("v%0d", idx);
        waitReady(tag);
        driveCmd(v.x, v.y, v.w, v.h, v.color);
        @(posedge main_clk);
        @(negedge main_clk);
        scrambleCmd();
        checkOutput({tag, " k0 do_write"}, 32'(do_write), 32'd0);
        checkOutput({tag, " k0 busy"}, 32'(busy), 32'(v.expCount > 0));
        checkOutput({tag, " k0 ready"}, 32'(cmd_ready), 32'(v.expCount == 0));
        for (int k = 1; k <= v.expCount + 1; k++) begin
            @(negedge main_clk);
            checkOutput({tag, " do_write"}, 32'(do_write), 32'(k <= v.expCount));
            checkOutput({tag, " busy"}, 32'(busy), 32'(k < v.expCount));
            checkOutput({tag, " ready"}, 32'(cmd_ready), 32'(k >= v.expCount));
            if (do_write === 1'b1) begin
                expAddr = (v.y + writes / v.expWeff) * 320 + v.x + writes % v.expWeff;
                checkOutput({tag, " addr"}, 32'(write_addr), 32'(expAddr));
                checkOutput({tag, " data"}, 32'(write_data), 32'(v.color));
                if (writes == 0) firstAddr = int'(write_addr);
                lastAddr = int'(write_addr);
                writes++;
            end
        end
        checkOutput({tag, " write count"}, 32'(writes), 32'(v.expCount));
        if (v.expCount > 0) begin
            checkOutput({tag, " first addr"}, 32'(firstAddr), 32'(v.expFirst));
            checkOutput({tag, " last addr"}, 32'(lastAddr), 32'(v.expLast));
        end
    endtask

    initial begin
        int writes;

        //            x    y    w    h    color    cnt    weff  first  last
        vecs[0] = '{  5,   2,   1,   1, 'hF00,     1,     1,   645,   645};
        vecs[1] = '{318, 198,   3,   3, 'h0AB,     4,     2, 63678, 63999};
        vecs[2] = '{ 10,  10,   0,   5, 'h111,     0,     1,     0,     0};
        vecs[3] = '{ 10,  10,   5,   0, 'h222,     0,     1,     0,     0};
        vecs[4] = '{320,   0,   4,   4, 'h333,     0,     1,     0,     0};
        vecs[5] = '{  0, 200,   4,   4, 'h444,     0,     1,     0,     0};
        vecs[6] = '{  7,   3,   3,   2, 'h0F0,     6,     3,   967,  1289};
        vecs[7] = '{511, 255,   9,   9, 'h555,     0,     1,     0,     0};
        vecs[8] = '{300,  10, 100,   1, 'h00F,    20,    20,  3500,  3519};
        vecs[9] = '{  0,   0, 320, 200, 'hABC, 64000,   320,     0, 63999};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        cmd_w = '0;
        cmd_h = '0;
        cmd_color = '0;
        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        checkOutput("reset do_write", 32'(do_write), 32'd0);
        checkOutput("reset write_addr", 32'(write_addr), 32'd0);
        checkOutput("reset write_data", 32'(write_data), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        @(negedge main_clk);
        checkOutput("post-reset ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-to-back: second command held on the bus while the first fills.
        waitReady("b2b");
        driveCmd(0, 0, 2, 1, 'h123);
        @(posedge main_clk);
        @(negedge main_clk);
        driveCmd(10, 0, 1, 1, 'h456);
        checkOutput("b2b k0 do_write", 32'(do_write), 32'd0);
        @(negedge main_clk);
        checkOutput("b2b k1 do_write", 32'(do_write), 32'd1);
        checkOutput("b2b k1 addr", 32'(write_addr), 32'd0);
        checkOutput("b2b k1 ready", 32'(cmd_ready), 32'd0);
        @(negedge main_clk);
        checkOutput("b2b k2 do_write", 32'(do_write), 32'd1);
        checkOutput("b2b k2 addr", 32'(write_addr), 32'd1);
        checkOutput("b2b k2 ready", 32'(cmd_ready), 32'd1);
        @(negedge main_clk);
        scrambleCmd();
        checkOutput("b2b k3 idle do_write", 32'(do_write), 32'd0);
        checkOutput("b2b k3 busy", 32'(busy), 32'd1);
        @(negedge main_clk);
        checkOutput("b2b k4 do_write", 32'(do_write), 32'd1);
        checkOutput("b2b k4 addr", 32'(write_addr), 32'd10);
        checkOutput("b2b k4 data", 32'(write_data), 32'h456);
        checkOutput("b2b k4 ready", 32'(cmd_ready), 32'd1);
        @(negedge main_clk);
        checkOutput("b2b k5 do_write", 32'(do_write), 32'd0);
        checkOutput("b2b k5 addr hold", 32'(write_addr), 32'd10);

        // Reset asserted while the 5th write of a 10x1 fill is on the port.
        waitReady("rst");
        driveCmd(20, 0, 10, 1, 'h777);
        @(posedge main_clk);
        @(negedge main_clk);
        scrambleCmd();
        repeat (5) @(negedge main_clk);
        checkOutput("rst 5th write", 32'(do_write), 32'd1);
        checkOutput("rst 5th addr", 32'(write_addr), 32'd24);
        reset = 1'b1;
        @(negedge main_clk);
        checkOutput("rst do_write", 32'(do_write), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst write_addr", 32'(write_addr), 32'd0);
        reset = 1'b0;
        @(negedge main_clk);
        checkOutput("rst release ready", 32'(cmd_ready), 32'd1);
        writes = 0;
        for (int k = 0; k < 12; k++) begin
            if (do_write === 1'b1) writes++;
            @(negedge main_clk);
        end
        checkOutput("rst no further writes", 32'(writes), 32'd0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
